spi_slave_modes: RTL and testbench

SPI_SLAVE_MODES -- requirements
Module: spi_slave_modes

---
 rtl/spi_slave_modes.sv | 179 +++++++++++++++++
 tb/tb_spi_slave_modes.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_modes.sv
// SPI slave with build-time CPOL/CPHA/bit-order selection.
// All SPI pins are synchronised into the sclk domain, and edges are detected there.
// A TX holding register decouples the host load strobe from word boundaries.
module spi_slave_modes #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        CPOL       = 1'b0,
    parameter logic        CPHA       = 1'b0,
    parameter logic        MSB_FIRST  = 1'b1
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  underrun
);

    localparam int unsigned     CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic clk_s1, clk_s2, clk_h;
    logic cs_s1, cs_s2, cs_h;
    logic mosi_s1, mosi_s2;

    logic [1:0]            settle;
    logic                  armed;
    logic                  need_start;
    logic                  under_pend;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_hold;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [CNT_W-1:0]      bit_cnt;

    logic                  active;
    logic                  cs_fall;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_edge;
    logic                  shift_edge;
    logic                  word_start;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] tx_next;

    // Two-flop synchronisers plus history flops for edge detection on spi_clk and cs_n.
    always_ff @(posedge sclk) begin
        if (rst) begin
            clk_s1  <= CPOL;
            clk_s2  <= CPOL;
            clk_h   <= CPOL;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_h    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            clk_s1  <= spi_clk;
            clk_s2  <= clk_s1;
            clk_h   <= clk_s2;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            cs_h    <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // Edge classification, word-start decision and next shift-register contents.
    always_comb begin
        active      = armed && !cs_s2;
        cs_fall     = active && cs_h;
        lead_edge   = active && (clk_h == CPOL) && (clk_s2 != CPOL);
        trail_edge  = active && (clk_h != CPOL) && (clk_s2 == CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        word_start  = (!CPHA && cs_fall) || (shift_edge && need_start);

        if (MSB_FIRST) begin
            rx_next = {rx_sh[DATA_WIDTH-2:0], mosi_s2};
        end else begin
            rx_next = {mosi_s2, rx_sh[DATA_WIDTH-1:1]};
        end

        tx_next = tx_sh;
        if (word_start) begin
            tx_next = tx_valid ? tx_hold : '0;
        end else if (shift_edge) begin
            if (MSB_FIRST) begin
                tx_next = {tx_sh[DATA_WIDTH-2:0], 1'b0};
            end else begin
                tx_next = {1'b0, tx_sh[DATA_WIDTH-1:1]};
            end
        end
    end

    // Transfer engine: TX holding/shift, RX assembly, bit counter and status pulses.
    // Underrun is reported at the first sample of a word, so a speculative word
    // start at the tail of a frame that the master never clocks is not flagged.
    always_ff @(posedge sclk) begin
        if (rst) begin
            settle     <= 2'd0;
            armed      <= 1'b0;
            need_start <= 1'b0;
            under_pend <= 1'b0;
            tx_valid   <= 1'b0;
            tx_hold    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            bit_cnt    <= '0;
            miso       <= 1'b0;
            data_out   <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            busy     <= active;

            // Only a cs_n seen idle after the chain settles arms the block.
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd3 && cs_s2) begin
                armed <= 1'b1;
            end

            if (!active) begin
                bit_cnt    <= '0;
                rx_sh      <= '0;
                tx_sh      <= '0;
                need_start <= 1'b0;
                under_pend <= 1'b0;
                miso       <= 1'b0;
            end else begin
                tx_sh <= tx_next;
                miso  <= MSB_FIRST ? tx_next[DATA_WIDTH-1] : tx_next[0];

                if (cs_fall) begin
                    need_start <= CPHA;
                end
                if (word_start) begin
                    need_start <= 1'b0;
                    under_pend <= !tx_valid;
                    tx_valid   <= 1'b0;
                end

                if (sample_edge) begin
                    rx_sh <= rx_next;
                    if (bit_cnt == '0) begin
                        underrun   <= under_pend;
                        under_pend <= 1'b0;
                    end
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt    <= '0;
                        data_out   <= rx_next;
                        done       <= 1'b1;
                        need_start <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end

            // A host load wins over the clear from a simultaneous word start.
            if (load) begin
                tx_hold  <= data_in;
                tx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_modes.sv
// Scoreboard bench for spi_slave_modes across six parameter builds.
module tb_spi_slave_modes;

    localparam int NI = 6;
    localparam int H  = 6;

    typedef struct {
        int          inst;
        logic [31:0] val;
    } exp_t;

    logic        sclk = 1'b0;
    logic        rst;
    logic        spi_clk  [NI];
    logic        cs_n     [NI];
    logic        mosi     [NI];
    logic        load     [NI];
    logic [15:0] din      [NI];
    logic        miso     [NI];
    logic        done     [NI];
    logic        busy     [NI];
    logic        underrun [NI];
    logic [31:0] dout     [NI];

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          last_edge [NI];
    int          under_cnt [NI];
    int          exp_under [NI];
    bit          hold_valid[NI];
    logic [31:0] hold_val  [NI];
    exp_t        sb_q[$];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    function automatic int width_of(input int g);
        return (g == 5) ? 16 : 8;
    endfunction
    function automatic bit cpol_of(input int g);
        return (g == 3 || g == 4);
    endfunction
    function automatic bit cpha_of(input int g);
        return (g == 2 || g == 4);
    endfunction
    function automatic bit msb_of(input int g);
        return (g == 0 || g == 5);
    endfunction
    function automatic logic [31:0] mask_of(input int g);
        return (32'd1 << width_of(g)) - 32'd1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned W = (g == 5) ? 16 : 8;
        logic [W-1:0] dout_w;
        spi_slave_modes #(
            .DATA_WIDTH (W),
            .CPOL       ((g == 3 || g == 4) ? 1'b1 : 1'b0),
            .CPHA       ((g == 2 || g == 4) ? 1'b1 : 1'b0),
            .MSB_FIRST  ((g == 0 || g == 5) ? 1'b1 : 1'b0)
        ) u_dut (
            .sclk     (sclk),
            .rst      (rst),
            .spi_clk  (spi_clk[g]),
            .cs_n     (cs_n[g]),
            .mosi     (mosi[g]),
            .miso     (miso[g]),
            .data_in  (din[g][W-1:0]),
            .load     (load[g]),
            .data_out (dout_w),
            .done     (done[g]),
            .busy     (busy[g]),
            .underrun (underrun[g])
        );
        assign dout[g] = 32'(dout_w);
    end

    // Monitor: pops the scoreboard whenever any build reports a finished word.
    always @(negedge sclk) begin
        if (rst !== 1'b1) begin
            for (int g = 0; g < NI; g++) begin
                if (underrun[g] === 1'b1) under_cnt[g]++;
                if (done[g] === 1'b1) begin
                    vectors++;
                    if (sb_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_done inst=%0d got=%h required=none", g, dout[g]);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        if (e.inst != g || dout[g] !== e.val) begin
                            miscompares++;
                            $display("FAIL done_data inst=%0d got=%h required inst=%0d val=%h",
                                     g, dout[g], e.inst, e.val);
                        end
                    end
                    vectors++;
                    if (cyc - last_edge[g] > 4) begin
                        miscompares++;
                        $display("FAIL done_latency inst=%0d got=%0d required<=4", g, cyc - last_edge[g]);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Reference model of the TX holding register.
    task automatic do_load(input int g, input logic [31:0] v);
        din[g]  = 16'(v);
        load[g] = 1'b1;
        tick(1);
        load[g] = 1'b0;
        hold_val[g]   = v & mask_of(g);
        hold_valid[g] = 1'b1;
    endtask

    task automatic fetch(input int g, output logic [31:0] v);
        if (hold_valid[g]) begin
            v = hold_val[g];
            hold_valid[g] = 1'b0;
        end else begin
            v = 32'd0;
            exp_under[g]++;
        end
    endtask

    task automatic set_cs(input int g, input logic v);
        cs_n[g] = v;
        tick(8);
    endtask

    // One SPI bit as the master sees it; returns the miso bit the master samples.
    task automatic do_bit(input int g, input logic b, output logic m, input bit final_bit);
        if (!cpha_of(g)) begin
            mosi[g] = b;
            tick(H);
            m = miso[g];
            spi_clk[g] = ~cpol_of(g);
            if (final_bit) last_edge[g] = cyc;
            tick(H);
            spi_clk[g] = cpol_of(g);
        end else begin
            spi_clk[g] = ~cpol_of(g);
            mosi[g] = b;
            tick(H);
            m = miso[g];
            spi_clk[g] = cpol_of(g);
            if (final_bit) last_edge[g] = cyc;
            tick(H);
        end
    endtask

    task automatic frame(input int g, input int nw, input logic [31:0] w0, input logic [31:0] w1,
                         input bit mid_load, input logic [31:0] mid_val);
        logic [31:0] words [2];
        logic [31:0] tx, rx;
        logic        m;
        int          w_bits, idx;
        w_bits   = width_of(g);
        words[0] = w0 & mask_of(g);
        words[1] = w1 & mask_of(g);
        set_cs(g, 1'b0);
        for (int w = 0; w < nw; w++) begin
            fetch(g, tx);
            sb_q.push_back('{inst: g, val: words[w]});
            rx = 32'd0;
            for (int i = 0; i < w_bits; i++) begin
                idx = msb_of(g) ? (w_bits - 1 - i) : i;
                do_bit(g, words[w][idx], m, i == w_bits - 1);
                rx[idx] = m;
                if (mid_load && w == 0 && i == w_bits / 2) do_load(g, mid_val);
            end
            check($sformatf("miso_word_i%0d_w%0d", g, w), rx, tx);
        end
        tick(H);
        set_cs(g, 1'b1);
        check($sformatf("miso_idle_i%0d", g), 32'(miso[g]), 32'd0);
    endtask

    task automatic partial(input int g, input int nbits, input logic [31:0] wv);
        logic [31:0] tx;
        logic        m;
        int          idx;
        set_cs(g, 1'b0);
        fetch(g, tx);
        for (int i = 0; i < nbits; i++) begin
            idx = msb_of(g) ? (width_of(g) - 1 - i) : i;
            do_bit(g, wv[idx], m, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(miso[0]), 32'd0);
        check({tag, "_data_out"}, dout[0], 32'd0);
        check({tag, "_done"}, 32'(done[0]), 32'd0);
        check({tag, "_busy"}, 32'(busy[0]), 32'd0);
        check({tag, "_underrun"}, 32'(underrun[0]), 32'd0);
    endtask

    initial begin
        logic m;
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            spi_clk[g] = cpol_of(g);
            cs_n[g] = 1'b1;
            mosi[g] = 1'b0;
            load[g] = 1'b0;
            din[g] = 16'd0;
            last_edge[g] = 0;
            under_cnt[g] = 0;
            exp_under[g] = 0;
            hold_valid[g] = 1'b0;
            hold_val[g] = 32'd0;
        end
        tick(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(6);

        // Mode 0, MSB first.
        do_load(0, 32'hAA);
        frame(0, 1, 32'hCC, 32'h0, 1'b0, 32'h0);

        // All four clock modes, LSB first.
        for (int g = 1; g <= 4; g++) begin
            do_load(g, 32'h3C);
            frame(g, 1, 32'hA5, 32'h0, 1'b0, 32'h0);
        end

        // 16-bit back-to-back words with the second load during the first word.
        do_load(5, 32'h1234);
        frame(5, 2, 32'h1234, 32'hBEEF, 1'b1, 32'hBEEF);
        tick(4);
        check("underrun_w16_none", 32'(under_cnt[5]), 32'd0);

        // No load: zeros sent and one underrun.
        frame(0, 1, 32'h5A, 32'h0, 1'b0, 32'h0);
        tick(4);
        check("underrun_count_no_load", 32'(under_cnt[0]), 32'(exp_under[0]));

        // Abort after five bits, then a full word.
        partial(0, 5, 32'hF0);
        tick(H);
        set_cs(0, 1'b1);
        check("miso_cs_high_a", 32'(miso[0]), 32'd0);
        tick(7);
        check("miso_cs_high_b", 32'(miso[0]), 32'd0);
        frame(0, 1, 32'h81, 32'h0, 1'b0, 32'h0);

        // Reset mid-word, master keeps clocking with cs_n still low.
        do_load(0, 32'h33);
        partial(0, 3, 32'h96);
        rst = 1'b1;
        tick(2);
        check_reset_outputs("midrst");
        rst = 1'b0;
        for (int g = 0; g < NI; g++) hold_valid[g] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_bit(0, 1'b1, m, 1'b0);
            check("miso_after_rst", 32'(m), 32'd0);
        end
        tick(H);
        set_cs(0, 1'b1);
        frame(0, 1, 32'h7E, 32'h0, 1'b0, 32'h0);

        // Randomised frames across every build.
        for (int k = 0; k < 40; k++) begin
            int g, nw;
            bit mid;
            g   = int'($urandom_range(0, NI - 1));
            nw  = int'($urandom_range(1, 2));
            mid = (nw == 2) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) do_load(g, $urandom);
            frame(g, nw, $urandom, $urandom, mid, $urandom);
        end

        tick(20);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("underrun_total_i%0d", g), 32'(under_cnt[g]), 32'(exp_under[g]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
